alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter N_BITS, default 8, operand/result width (legal range 6..32).
REQ-002 SHALL have parameter DEB_CYCLES, default 16, debounce stability count in clock cycles (used only with BTN_DEBOUNCE_EN).
REQ-003 SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_SWs  input  N_BITS  switch data; operand value, or opcode in bits [5:0].
REQ-006 SHALL have port i_buttons  input  3  raw buttons; [2]=load A, [1]=load B, [0]=load OP.
REQ-007 SHALL have port o_led  output  N_BITS  registered result.
REQ-008 SHALL have port o_flags  output  4  registered {negative, overflow, carry, zero}.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse when o_led/o_flags update.
REQ-010 SHALL have port o_err  output  1  sticky invalid-opcode indication.
REQ-011 SHALL have port o_state  output  2  current FSM state encoding.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer and a rising-edge detector, giving a one-cycle press event per press.
REQ-013 SHALL ignore any cycle in which more than one press event occurs.
REQ-014 SHALL implement FSM states WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3.
REQ-015 SHALL, on an A event in any state other than EXEC, latch i_SWs into reg_A, clear o_err, and go to WAIT_B.
REQ-016 SHALL, on a B event in WAIT_B, latch i_SWs into reg_B and go to WAIT_OP; B events in other states are ignored.
REQ-017 SHALL, on an OP event in WAIT_OP with a valid i_SWs[5:0], latch the opcode and go to EXEC.
REQ-018 SHALL, on an OP event in WAIT_OP with an invalid opcode, set o_err, keep reg_A, reg_B and o_led, and stay in WAIT_OP.
REQ-019 SHALL decode opcodes ADD=100000, SUB=100010, AND=100100, OR=100101, XOR=100110, NOR=100111, SRL=000010 and SRA=000011; all others are invalid.
REQ-020 SHALL, in EXEC, register the result into o_led and the flags into o_flags, pulse o_valid for that cycle, and go to WAIT_A; press events in EXEC are dropped.
REQ-021 SHALL make o_valid rise exactly 2 clock edges after the OP press event cycle.
REQ-022 SHALL set carry to the ADD carry-out and to the SUB borrow (A<B unsigned); carry SHALL be 0 for all other ops.
REQ-023 SHALL set overflow to two's-complement overflow for ADD and SUB; overflow SHALL be 0 for all other ops.
REQ-024 SHALL set zero to (result==0) and negative to result MSB for every op.
REQ-025 SHALL shift by the unsigned value of reg_B.
REQ-026 SHALL make SRL zero-fill and SRA sign-fill.
REQ-027 SHALL make a shift amount >= N_BITS give 0 for SRL and all-sign-bits for SRA.
REQ-028 SHALL hold o_led and o_flags between EXEC cycles.

Reset
REQ-029 SHALL, while reset is low, asynchronously force state=WAIT_A, reg_A=reg_B=0, o_led=0, o_flags=0, o_valid=0, o_err=0, and clear synchronizers, edge detectors and debounce counters.
REQ-030 SHALL make reset asserted mid-sequence, including during EXEC, discard the pending operation with no o_valid pulse.

Configuration
REQ-031 SHALL, with BTN_DEBOUNCE_EN defined, generate a press event only after a synchronized button is high for DEB_CYCLES consecutive cycles, re-arming only after it is low for DEB_CYCLES cycles.
REQ-032 SHALL, with BTN_DEBOUNCE_EN undefined, omit the debounce logic so that a press event occurs on the cycle after the synchronized rising edge.

Verification (N_BITS=8, BTN_DEBOUNCE_EN undefined unless stated)
REQ-033 SHALL cover: A=0x7F, B=0x01, ADD -> o_led=0x80, o_flags={N=1,V=1,C=0,Z=0}, one o_valid pulse.
REQ-034 SHALL cover: A=0x05, B=0x07, SUB -> o_led=0xFE, C=1, N=1, V=0.
REQ-035 SHALL cover: A=0x90, B=2 -> SRA gives 0xE4 and SRL gives 0x24; A=0x90, B=9 -> SRA gives 0xFF and SRL gives 0x00 with Z=1.
REQ-036 SHALL cover: A=0x0F, B=0xF0, NOR -> 0x00 with Z=1; then opcode 111111 -> o_err=1, o_led stays 0x00, state=WAIT_OP, and a subsequent A press clears o_err.
REQ-037 SHALL cover: A and B pressed in the same cycle -> ignored, state unchanged; B pressed in WAIT_A -> ignored; A re-pressed in WAIT_OP -> reg_A reloaded, state=WAIT_B.
REQ-038 SHALL cover, with BTN_DEBOUNCE_EN defined and DEB_CYCLES=16: a 10-cycle A pulse loads nothing, while a 20-cycle pulse loads A exactly once; reset low during EXEC -> o_led=0 and no o_valid pulse.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: operands and an opcode are loaded from switches by
// pressing buttons, then the operation is executed and registered.
//
// Ports:
//   clock      - system clock, all state on rising edge
//   reset      - asynchronous active-low reset
//   i_SWs      - switch data (operand, or opcode in [5:0])
//   i_buttons  - raw buttons: [2]=load A, [1]=load B, [0]=load OP
//   o_led      - registered result
//   o_flags    - registered {negative, overflow, carry, zero}
//   o_valid    - one-cycle pulse when o_led/o_flags update
//   o_err      - sticky invalid-opcode indication (cleared by an A load)
//   o_state    - FSM state: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3
//
// Optional feature: define BTN_DEBOUNCE_EN to debounce the synchronized
// buttons for DEB_CYCLES cycles in each direction before a press counts.
module alu_sequencer #(
  parameter int N_BITS     = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_SWs,
  input  logic [2:0]        i_buttons,
  output logic [N_BITS-1:0] o_led,
  output logic [3:0]        o_flags,
  output logic              o_valid,
  output logic              o_err,
  output logic [1:0]        o_state
);

  localparam logic [1:0] S_WA = 2'd0, S_WB = 2'd1, S_WOP = 2'd2, S_EXEC = 2'd3;
  localparam logic [5:0] OP_ADD = 6'b100000, OP_SUB = 6'b100010,
                         OP_AND = 6'b100100, OP_OR  = 6'b100101,
                         OP_XOR = 6'b100110, OP_NOR = 6'b100111,
                         OP_SRL = 6'b000010, OP_SRA = 6'b000011;
  localparam int          MSB  = N_BITS - 1;
  localparam logic [N_BITS-1:0] LP_W = N_BITS'(N_BITS);

  logic [2:0]        r_sync1, r_sync2;
  logic [2:0]        w_ev;
  logic [1:0]        r_state, w_next;
  logic [N_BITS-1:0] r_a, r_b, r_led;
  logic [5:0]        r_op;
  logic [3:0]        r_flags;
  logic              r_valid, r_err;

  // Two-flop synchronizer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_buttons;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    r_stable, r_deb_ev;

  // Stable level flips only after DEB_CYCLES consecutive disagreeing
  // samples; a flip to 1 is the press event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stable <= '0;
      r_deb_ev <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_deb_ev[i] <= 1'b0;
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
            r_stable[i] <= r_sync2[i];
            r_deb_ev[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end
  assign w_ev = r_deb_ev;
`else
  logic [2:0] r_prev;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_prev <= '0;
    else        r_prev <= r_sync2;
  end
  assign w_ev = r_sync2 & ~r_prev;
`endif

  // Simultaneous presses are discarded entirely
  logic w_one, w_a, w_b, w_opev, w_op_ok;
  assign w_one  = $onehot(w_ev);
  assign w_a    = w_one & w_ev[2];
  assign w_b    = w_one & w_ev[1];
  assign w_opev = w_one & w_ev[0];

  always_comb begin
    case (i_SWs[5:0])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA: w_op_ok = 1'b1;
      default: w_op_ok = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_WA;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WA:    if (w_a) w_next = S_WB;
      S_WB:    if (w_b) w_next = S_WOP;
      S_WOP:   if (w_a) w_next = S_WB;
               else if (w_opev && w_op_ok) w_next = S_EXEC;
      default: w_next = S_WA;
    endcase
  end

  // FSM: outputs (datapath controls)
  logic w_load_a, w_load_b, w_load_op, w_set_err, w_exec;
  always_comb begin
    w_load_a  = w_a && (r_state != S_EXEC);
    w_load_b  = w_b && (r_state == S_WB);
    w_load_op = w_opev && (r_state == S_WOP) && w_op_ok;
    w_set_err = w_opev && (r_state == S_WOP) && !w_op_ok;
    w_exec    = (r_state == S_EXEC);
  end

  // ALU
  logic [N_BITS:0]   w_sum, w_diff;
  logic [N_BITS-1:0] w_res;
  logic              w_c, w_v;
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};   // top bit is the borrow

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum[N_BITS-1:0];
        w_c   = w_sum[N_BITS];
        w_v   = (r_a[MSB] == r_b[MSB]) && (w_res[MSB] != r_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[N_BITS-1:0];
        w_c   = w_diff[N_BITS];
        w_v   = (r_a[MSB] != r_b[MSB]) && (w_res[MSB] != r_a[MSB]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOR: w_res = ~(r_a | r_b);
      OP_SRL: w_res = (r_b >= LP_W) ? '0 : (r_a >> r_b);
      OP_SRA: w_res = (r_b >= LP_W) ? {N_BITS{r_a[MSB]}}
                                    : N_BITS'($signed(r_a) >>> r_b);
      default: w_res = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_led   <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_exec;
      if (w_load_a)  r_a  <= i_SWs;
      if (w_load_b)  r_b  <= i_SWs;
      if (w_load_op) r_op <= i_SWs[5:0];
      if (w_load_a)       r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;
      if (w_exec) begin
        r_led   <= w_res;
        r_flags <= {w_res[MSB], w_v, w_c, (w_res == '0)};
      end
    end
  end

  assign o_led   = r_led;
  assign o_flags = r_flags;
  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  localparam int NB = 8;
`ifdef BTN_DEBOUNCE_EN
  localparam int HOLD = 20;
`else
  localparam int HOLD = 3;
`endif
  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100,
                         OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111,
                         SRL = 6'b000010, SRA = 6'b000011;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] i_SWs = '0;
  logic [2:0]    i_buttons = '0;
  logic [NB-1:0] o_led;
  logic [3:0]    o_flags;
  logic          o_valid, o_err;
  logic [1:0]    o_state;

  alu_sequencer #(.N_BITS(NB), .DEB_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .i_SWs(i_SWs), .i_buttons(i_buttons),
    .o_led(o_led), .o_flags(o_flags), .o_valid(o_valid), .o_err(o_err),
    .o_state(o_state));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int valid_cnt = 0;
  always @(negedge clock) if (o_valid === 1'b1) valid_cnt++;

  // Reference model, in terms of what the user sees
  int       m_state = 0;
  logic [7:0] m_a = 0, m_b = 0, m_led = 0;
  logic [3:0] m_flags = 0;
  bit       m_err = 0;
  int       m_valid = 0;

  function automatic bit op_valid(input logic [5:0] op);
    return op inside {ADD, SUB, AND_, OR_, XOR_, NOR_, SRL, SRA};
  endfunction

  function automatic int sval(input logic [7:0] v);
    return (v >= 128) ? int'(v) - 256 : int'(v);
  endfunction

  task automatic model_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                           output logic [7:0] res, output logic [3:0] fl);
    int r, s; bit c, v;
    c = 0; v = 0; r = 0;
    case (op)
      ADD: begin r = int'(a) + int'(b); c = r > 255; s = sval(a) + sval(b); v = s > 127 || s < -128; end
      SUB: begin r = int'(a) - int'(b); c = a < b;  s = sval(a) - sval(b); v = s > 127 || s < -128; end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      NOR_: r = ~(a | b);
      SRL:  r = (b >= 8) ? 0 : int'(a) / (1 << b);
      SRA:  r = (b >= 8) ? ((a >= 128) ? 255 : 0) : (sval(a) >>> b);
      default: r = 0;
    endcase
    res = r[7:0];
    fl  = {res[7], v, c, res == 8'h00};
  endtask

  task automatic model_press(input logic [2:0] mask, input logic [7:0] sw);
    if ($countones(mask) != 1) return;
    if (mask[2]) begin
      m_a = sw; m_err = 0; m_state = 1;
    end else if (mask[1]) begin
      if (m_state == 1) begin m_b = sw; m_state = 2; end
    end else if (m_state == 2) begin
      if (op_valid(sw[5:0])) begin
        model_alu(m_a, m_b, sw[5:0], m_led, m_flags);
        m_valid++; m_state = 0;
      end else m_err = 1;
    end
  endtask

  task automatic press(input logic [2:0] mask, input logic [7:0] sw);
    @(negedge clock);
    i_SWs = sw; i_buttons = mask;
    repeat (HOLD) @(negedge clock);
    i_buttons = '0;
    repeat (HOLD + 6) @(negedge clock);
    model_press(mask, sw);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 0;
    i_buttons = '0;
    repeat (3) @(negedge clock);
    reset = 1;
    repeat (2) @(negedge clock);
    m_state = 0; m_a = 0; m_b = 0; m_led = 0; m_flags = 0; m_err = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clock);
    total += 5;
    if (o_led !== 8'h00)   begin bad++; $display("FAIL reset_led got=%h want=00", o_led); end
    if (o_flags !== 4'h0)  begin bad++; $display("FAIL reset_flags got=%b want=0000", o_flags); end
    if (o_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    if (o_err !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b want=0", o_err); end
    if (o_state !== 2'd0)  begin bad++; $display("FAIL reset_state got=%0d want=0", o_state); end
    reset = 1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_arith();
    int v0;
    v0 = valid_cnt;
    press(3'b100, 8'h7F); press(3'b010, 8'h01); press(3'b001, {2'b00, ADD});
    total += 3;
    if (o_led !== 8'h80)    begin bad++; $display("FAIL add_ovf_led got=%h want=80", o_led); end
    if (o_flags !== 4'b1100) begin bad++; $display("FAIL add_ovf_flags got=%b want=1100", o_flags); end
    if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL add_ovf_pulses got=%0d want=1", valid_cnt - v0); end
    press(3'b100, 8'h05); press(3'b010, 8'h07); press(3'b001, {2'b00, SUB});
    total += 2;
    if (o_led !== 8'hFE)    begin bad++; $display("FAIL sub_borrow_led got=%h want=fe", o_led); end
    if (o_flags !== 4'b1010) begin bad++; $display("FAIL sub_borrow_flags got=%b want=1010", o_flags); end
  endtask

  task automatic test_shift();
    logic [7:0] bv [2] = '{8'd2, 8'd9};
    logic [7:0] want_led [4] = '{8'hE4, 8'h24, 8'hFF, 8'h00};
    logic [3:0] want_fl  [4] = '{4'b1000, 4'b0000, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      press(3'b100, 8'h90); press(3'b010, bv[i/2]);
      press(3'b001, {2'b00, (i % 2 == 0) ? SRA : SRL});
      total += 2;
      if (o_led !== want_led[i]) begin bad++; $display("FAIL shift_led[%0d] got=%h want=%h", i, o_led, want_led[i]); end
      if (o_flags !== want_fl[i]) begin bad++; $display("FAIL shift_flags[%0d] got=%b want=%b", i, o_flags, want_fl[i]); end
    end
  endtask

  task automatic test_err();
    int v0;
    press(3'b100, 8'h0F); press(3'b010, 8'hF0); press(3'b001, {2'b00, NOR_});
    total += 2;
    if (o_led !== 8'h00)     begin bad++; $display("FAIL nor_led got=%h want=00", o_led); end
    if (o_flags !== 4'b0001) begin bad++; $display("FAIL nor_flags got=%b want=0001", o_flags); end
    v0 = valid_cnt;
    press(3'b100, 8'h12); press(3'b010, 8'h34); press(3'b001, 8'h3F);
    total += 4;
    if (o_err !== 1'b1)     begin bad++; $display("FAIL bad_op_err got=%b want=1", o_err); end
    if (o_led !== 8'h00)    begin bad++; $display("FAIL bad_op_led got=%h want=00", o_led); end
    if (o_state !== 2'd2)   begin bad++; $display("FAIL bad_op_state got=%0d want=2", o_state); end
    if (valid_cnt !== v0)   begin bad++; $display("FAIL bad_op_pulse got=%0d want=%0d", valid_cnt, v0); end
    press(3'b100, 8'h01);
    total += 2;
    if (o_err !== 1'b0)   begin bad++; $display("FAIL err_clear got=%b want=0", o_err); end
    if (o_state !== 2'd1) begin bad++; $display("FAIL err_clear_state got=%0d want=1", o_state); end
  endtask

  task automatic test_ignore();
    // now in WAIT_B with A=0x01
    press(3'b110, 8'h55);
    total++;
    if (o_state !== 2'd1) begin bad++; $display("FAIL dual_press_state got=%0d want=1", o_state); end
    press(3'b010, 8'h10);
    press(3'b100, 8'h20);
    total++;
    if (o_state !== 2'd1) begin bad++; $display("FAIL reload_a_state got=%0d want=1", o_state); end
    press(3'b010, 8'h03); press(3'b001, {2'b00, ADD});
    total++;
    if (o_led !== 8'h23) begin bad++; $display("FAIL reload_a_result got=%h want=23", o_led); end
    press(3'b010, 8'h44);
    total++;
    if (o_state !== 2'd0) begin bad++; $display("FAIL b_in_wait_a got=%0d want=0", o_state); end
  endtask

  task automatic test_latency();
    bit want;
    press(3'b100, 8'h40); press(3'b010, 8'h02);
    @(negedge clock);
    i_SWs = {2'b00, SUB}; i_buttons = 3'b001;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == HOLD) i_buttons = '0;
      want = (k == 4);
      total++;
      if (o_valid !== want) begin bad++; $display("FAIL latency_k%0d got=%b want=%b", k, o_valid, want); end
    end
    i_buttons = '0;
    repeat (HOLD + 6) @(negedge clock);
    model_press(3'b001, {2'b00, SUB});
    total++;
    if (o_led !== m_led) begin bad++; $display("FAIL latency_led got=%h want=%h", o_led, m_led); end
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic [7:0] a, b;
    for (int it = 0; it < 24; it++) begin
      a = 8'($urandom); b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      op = 6'($urandom);
      if ($urandom_range(0, 7) != 0) begin
        case ($urandom_range(0, 7))
          0: op = ADD; 1: op = SUB; 2: op = AND_; 3: op = OR_;
          4: op = XOR_; 5: op = NOR_; 6: op = SRL; default: op = SRA;
        endcase
      end
      press(3'b100, a); press(3'b010, b);
      press(3'b001, {2'($urandom), op});
      total += 5;
      if (o_led !== m_led)     begin bad++; $display("FAIL rnd%0d_led a=%h b=%h op=%b got=%h want=%h", it, a, b, op, o_led, m_led); end
      if (o_flags !== m_flags) begin bad++; $display("FAIL rnd%0d_flags a=%h b=%h op=%b got=%b want=%b", it, a, b, op, o_flags, m_flags); end
      if (o_err !== m_err)     begin bad++; $display("FAIL rnd%0d_err got=%b want=%b", it, o_err, m_err); end
      if (o_state !== 2'(m_state)) begin bad++; $display("FAIL rnd%0d_state got=%0d want=%0d", it, o_state, m_state); end
      if (valid_cnt !== m_valid) begin bad++; $display("FAIL rnd%0d_pulses got=%0d want=%0d", it, valid_cnt, m_valid); end
    end
  endtask

  task automatic test_reset_exec();
    int v0, n;
    bit seen;
    press(3'b100, 8'h11); press(3'b010, 8'h22);
    v0 = valid_cnt;
    @(negedge clock);
    i_SWs = {2'b00, ADD}; i_buttons = 3'b001;
    seen = 0; n = 0;
    while (!seen && n < 60) begin
      @(negedge clock);
      n++;
      if (o_state === 2'd3) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL exec_reached got=timeout want=state3"); end
    reset = 0;
    #1;
    i_buttons = '0;
    total += 2;
    if (o_state !== 2'd0) begin bad++; $display("FAIL exec_reset_state got=%0d want=0", o_state); end
    if (o_led !== 8'h00)  begin bad++; $display("FAIL exec_reset_led got=%h want=00", o_led); end
    repeat (4) @(negedge clock);
    reset = 1;
    repeat (HOLD + 6) @(negedge clock);
    total++;
    if (valid_cnt !== v0) begin bad++; $display("FAIL exec_reset_pulse got=%0d want=%0d", valid_cnt - v0, 0); end
    m_state = 0; m_a = 0; m_b = 0; m_led = 0; m_flags = 0; m_err = 0;
  endtask

`ifdef BTN_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    @(negedge clock);
    i_SWs = 8'h33; i_buttons = 3'b100;
    repeat (10) @(negedge clock);
    i_buttons = '0;
    repeat (30) @(negedge clock);
    total++;
    if (o_state !== 2'd0) begin bad++; $display("FAIL deb_short_state got=%0d want=0", o_state); end
    i_buttons = 3'b100;
    repeat (20) @(negedge clock);
    i_buttons = '0;
    repeat (30) @(negedge clock);
    model_press(3'b100, 8'h33);
    total++;
    if (o_state !== 2'd1) begin bad++; $display("FAIL deb_long_state got=%0d want=1", o_state); end
    press(3'b010, 8'h01); press(3'b001, {2'b00, ADD});
    total++;
    if (o_led !== 8'h34) begin bad++; $display("FAIL deb_result got=%h want=34", o_led); end
  endtask
`endif

  initial begin
    reset = 0;
    test_reset();
    test_arith();
    test_shift();
    test_err();
    test_ignore();
`ifndef BTN_DEBOUNCE_EN
    test_latency();
`endif
    do_reset();
    test_random();
    test_reset_exec();
`ifdef BTN_DEBOUNCE_EN
    test_debounce();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
